// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit add/subtract that reuses one 4-bit CLA slice, LS nibble first.
// Holds the slice itself so the block is self-contained.

module CLA_adder4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flat lookahead equations; no ripple through the slice.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 overflow,
  output logic                 zero
);

  localparam int unsigned W = 4 * NIBBLES;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q;
  logic [W-1:0]   opa_q;
  logic [W-1:0]   opb_q;
  logic           carry_q;
  logic [2:0]     idx_q;

  logic [3:0]     nib_a;
  logic [3:0]     nib_b;
  logic [3:0]     slice_s;
  logic           slice_cout;
  logic [W-1:0]   sum_wr;
  logic           last_nib;

  always_comb begin
    nib_a  = '0;
    nib_b  = '0;
    sum_wr = sum;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == 3'(i)) begin
        nib_a              = opa_q[4*i +: 4];
        nib_b              = opb_q[4*i +: 4];
        sum_wr[4*i +: 4]   = slice_s;
      end
    end
  end

  assign last_nib = (idx_q == 3'(NIBBLES - 1));

  CLA_adder4bit u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            opa_q    <= a;
            opb_q    <= sub ? ~b : b;
            // Two's-complement subtract: +1 arrives as the first carry-in.
            carry_q  <= sub;
            idx_q    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          sum     <= sum_wr;
          carry_q <= slice_cout;
          if (last_nib) begin
            cout     <= slice_cout;
            overflow <= (opa_q[W-1] == opb_q[W-1]) && (slice_s[3] != opa_q[W-1]);
            zero     <= (sum_wr == '0);
            done     <= 1'b1;
            state_q  <= StDone;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomised and directed checks of nibble_serial_adder against an arithmetic reference model.

module tb_nibble_serial_adder;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(
    .NIBBLES (NIBBLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                       output logic [W-1:0] es, output logic ec, output logic eo,
                       output logic ez);
    longint ua, ub, sa, sb, r, sr, modv, half;
    modv = longint'(64'd1 << W);
    half = modv / 2;
    ua   = longint'(ma);
    ub   = longint'(mb);
    sa   = (ua >= half) ? ua - modv : ua;
    sb   = (ub >= half) ? ub - modv : ub;
    r    = msub ? ua - ub : ua + ub;
    if (r < 0) r = r + modv;
    es   = r[W-1:0];
    ec   = msub ? (ua >= ub) : ((ua + ub) >= modv);
    sr   = msub ? sa - sb : sa + sb;
    eo   = (sr >= half) || (sr < -half);
    ez   = (es == '0);
  endtask

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osub,
                        input bit poke);
    logic [W-1:0] es;
    logic         ec, eo, ez;
    model(oa, ob, osub, es, ec, eo, ez);
    @(negedge clk);
    a     = oa;
    b     = ob;
    sub   = osub;
    start = 1'b1;
    for (int cyc = 1; cyc <= int'(NIBBLES) + 1; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
      end
      check("busy_run", busy, 1'b1);
      check("done_pulse", done, (cyc == int'(NIBBLES) + 1));
      if (poke && (cyc == 2 || cyc == int'(NIBBLES) + 1)) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    check("sum", sum, es);
    check("cout", cout, ec);
    check("overflow", overflow, eo);
    check("zero", zero, ez);
    if (poke) begin
      @(negedge clk);
      start = 1'b0;
      check("busy_after_ignored", busy, 1'b0);
      check("done_after", done, 1'b0);
      check("sum_held", sum, es);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_flags", {cout, overflow, zero}, '0);
    rst = 1'b0;

    // Directed cases, issued back-to-back so each start lands in the cycle after done.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1);
    run_op(16'h1111, 16'h2222, 1'b0, 1'b1);

    // Reset in cycle 2, then reset together with start.
    @(negedge clk);
    a     = 16'h1234;
    b     = 16'h1111;
    sub   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_sum", sum, '0);
    check("midrst_flags", {cout, overflow, zero}, '0);
    start = 1'b1;
    @(negedge clk);
    check("rst_wins_busy", busy, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
